// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: FSM state encoding and
// the opcodes the sequencer treats specially.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StImmed  = 3'd3,
        StExec   = 3'd4
    } state_t;

    localparam logic [3:0] OPC_LDI  = 4'hD;
    localparam logic [3:0] OPC_RST0 = 4'hE;
    localparam logic [3:0] OPC_RST1 = 4'hF;

endpackage

// File: rtl/pc_counter.sv
// Program counter: wrap-around incrementer with a synchronous clear that wins over
// increment.
module pc_counter #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  INC,
    input  logic                  CLR,
    output logic [ADDR_WIDTH-1:0] PC
);

    logic [ADDR_WIDTH-1:0] r_pc;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc <= '0;
        end else if (CLR) begin
            r_pc <= '0;
        end else if (INC) begin
            r_pc <= r_pc + ADDR_WIDTH'(1);
        end
    end

    assign PC = r_pc;

endmodule

// File: rtl/program_sequencer.sv
// Fetch/decode/execute controller: owns PC, IR and the immediate register, and turns
// the decoder's level enables into one-cycle strobes issued only in EXEC.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 4,
    parameter int unsigned OP_WIDTH    = 2,
    parameter int unsigned ADDR_WIDTH  = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   RUN,
    input  logic                   STEP,
    output logic [ADDR_WIDTH-1:0]  PROG_ADDR,
    output logic                   PROG_RD,
    input  logic                   PROG_VALID,
    input  logic [INSTR_WIDTH-1:0] PROG_DATA,
    output logic [INSTR_WIDTH-1:0] INSTRUCTION,
    input  logic                   DEC_RESET,
    input  logic                   DEC_SEL,
    input  logic                   DEC_CE_R0,
    input  logic                   DEC_CE_ACC,
    input  logic [OP_WIDTH-1:0]    DEC_OP,
    output logic                   SEL_OUT,
    output logic [OP_WIDTH-1:0]    OP_OUT,
    output logic                   CE_R0_OUT,
    output logic                   CE_ACC_OUT,
    output logic                   ACC_CLR,
    output logic [INSTR_WIDTH-1:0] IMM,
    output logic                   RETIRE,
    output logic                   BUSY
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_prog_rd;
    logic                   r_exec;
    logic                   r_busy;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic [INSTR_WIDTH-1:0] r_imm;
    logic [ADDR_WIDTH-1:0]  w_pc;
    logic                   w_rd_ack;
    logic                   w_pc_clr;

    // PROG_VALID only matters while a read is outstanding.
    assign w_rd_ack = r_prog_rd & PROG_VALID;
    assign w_pc_clr = r_exec & DEC_RESET;

    pc_counter #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_pc (
        .CLK  (CLK),
        .RST_N(RST_N),
        .INC  (w_rd_ack),
        .CLR  (w_pc_clr),
        .PC   (w_pc)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (RUN || STEP) w_state_nxt = StFetch;
            StFetch:  if (PROG_VALID) w_state_nxt = StDecode;
            StDecode: w_state_nxt = DEC_SEL ? StImmed : StExec;
            StImmed:  if (PROG_VALID) w_state_nxt = StExec;
            StExec:   w_state_nxt = RUN ? StFetch : StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    // Control flags are registered from the next state so they align with r_state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= StIdle;
            r_prog_rd <= 1'b0;
            r_exec    <= 1'b0;
            r_busy    <= 1'b0;
            r_ir      <= '0;
            r_imm     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_prog_rd <= (w_state_nxt == StFetch) || (w_state_nxt == StImmed);
            r_exec    <= (w_state_nxt == StExec);
            r_busy    <= (w_state_nxt != StIdle);
            if (r_state == StFetch && PROG_VALID) begin
                r_ir <= PROG_DATA;
            end
            if (r_state == StImmed && PROG_VALID) begin
                r_imm <= PROG_DATA;
            end
        end
    end

    assign PROG_ADDR   = w_pc;
    assign PROG_RD     = r_prog_rd;
    assign INSTRUCTION = r_ir;
    assign IMM         = r_imm;
    assign SEL_OUT     = DEC_SEL;
    assign OP_OUT      = DEC_OP;
    assign CE_R0_OUT   = r_exec & DEC_CE_R0;
    assign CE_ACC_OUT  = r_exec & DEC_CE_ACC;
    assign ACC_CLR     = r_exec & DEC_RESET;
    assign RETIRE      = r_exec;
    assign BUSY        = r_busy;

`ifndef SYNTHESIS
    a_rd_held: assert property (@(posedge CLK) disable iff (!RST_N)
        (r_prog_rd && !PROG_VALID) |=> r_prog_rd);
    a_exec_single: assert property (@(posedge CLK) disable iff (!RST_N)
        r_exec |=> !r_exec);
    a_retire_busy: assert property (@(posedge CLK) disable iff (!RST_N)
        r_exec |-> r_busy);
    a_ir_stable: assert property (@(posedge CLK) disable iff (!RST_N)
        (r_state != StFetch) |=> $stable(r_ir));
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: a ROM with random wait states, a stub decoder and an
// instruction-level model that predicts reads, strobes, PC flow and latency.
module tb_program_sequencer;
    import seq_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N, RUN, STEP, PROG_VALID;
    logic [3:0] PROG_ADDR, PROG_DATA, INSTRUCTION, IMM;
    logic       PROG_RD, DEC_RESET, DEC_SEL, DEC_CE_R0, DEC_CE_ACC;
    logic [1:0] DEC_OP, OP_OUT;
    logic       SEL_OUT, CE_R0_OUT, CE_ACC_OUT, ACC_CLR, RETIRE, BUSY;

    program_sequencer #(.INSTR_WIDTH(4), .OP_WIDTH(2), .ADDR_WIDTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .STEP(STEP),
        .PROG_ADDR(PROG_ADDR), .PROG_RD(PROG_RD), .PROG_VALID(PROG_VALID),
        .PROG_DATA(PROG_DATA), .INSTRUCTION(INSTRUCTION),
        .DEC_RESET(DEC_RESET), .DEC_SEL(DEC_SEL), .DEC_CE_R0(DEC_CE_R0),
        .DEC_CE_ACC(DEC_CE_ACC), .DEC_OP(DEC_OP), .SEL_OUT(SEL_OUT), .OP_OUT(OP_OUT),
        .CE_R0_OUT(CE_R0_OUT), .CE_ACC_OUT(CE_ACC_OUT), .ACC_CLR(ACC_CLR), .IMM(IMM),
        .RETIRE(RETIRE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    logic [3:0] rom [16];
    logic [3:0] m_pc;
    int         n_pass = 0, n_total = 0, n_fail = 0;
    int         wmin = 0, wmax = 0, wait_cnt = 0, wait_tgt = 0, waits_acc = 0;
    bit         in_read = 0, mem_auto = 1;
    int         stray = 0;
    int         rd_q[$];

    // Stub decoder: {reset, sel, ce_r0, ce_acc, op}.
    function automatic logic [5:0] dec(input logic [3:0] op);
        logic rst, sel, r0, acc;
        rst = (op == OPC_RST0) || (op == OPC_RST1);
        sel = (op == OPC_LDI);
        r0  = sel || (op[3:2] == 2'b10);
        acc = !rst && !sel && (op[3:2] != 2'b10);
        return {rst, sel, r0, acc, op[1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        {DEC_RESET, DEC_SEL, DEC_CE_R0, DEC_CE_ACC, DEC_OP} = dec(INSTRUCTION);
        if (mem_auto) begin
            if (PROG_RD) begin
                if (!in_read) begin
                    in_read  = 1;
                    wait_cnt = 0;
                    wait_tgt = $urandom_range(wmax, wmin);
                end
                if (wait_cnt >= wait_tgt) begin
                    PROG_VALID = 1'b1;
                    PROG_DATA  = rom[PROG_ADDR];
                    waits_acc += wait_cnt;
                    in_read    = 0;
                end else begin
                    PROG_VALID = 1'b0;
                    PROG_DATA  = 'x;
                    wait_cnt++;
                end
            end else begin
                PROG_VALID = 1'b0;
                PROG_DATA  = 'x;
            end
        end
        #1;
        if (PROG_RD && PROG_VALID) rd_q.push_back(int'(PROG_ADDR));
        if (!RETIRE && (CE_R0_OUT || CE_ACC_OUT || ACC_CLR)) stray++;
        if (RETIRE && !BUSY) stray++;
    endtask

    // Runs until the next RETIRE and checks it against the instruction-level model.
    task automatic run_instr(input string tag, input int pre, output int lat);
        int         n;
        logic [3:0] op, a0, a1, imm;
        logic [5:0] d;
        bit         is_imm;
        n = pre;
        do begin
            tick();
            n++;
        end while (!RETIRE && n < 300);
        op     = rom[m_pc];
        a0     = m_pc;
        m_pc   = m_pc + 4'd1;
        is_imm = (op == OPC_LDI);
        a1     = m_pc;
        imm    = rom[m_pc];
        if (is_imm) m_pc = m_pc + 4'd1;
        d = dec(op);
        if (d[5]) m_pc = 4'd0;
        chk({tag, ".retire"}, RETIRE, 1);
        chk({tag, ".instr"}, INSTRUCTION, op);
        chk({tag, ".nreads"}, rd_q.size(), is_imm ? 2 : 1);
        if (rd_q.size() >= 1) chk({tag, ".addr0"}, rd_q[0], a0);
        if (is_imm && rd_q.size() >= 2) begin
            chk({tag, ".addr1"}, rd_q[1], a1);
            chk({tag, ".imm"}, IMM, imm);
        end
        chk({tag, ".sel"}, SEL_OUT, d[4]);
        chk({tag, ".ce_r0"}, CE_R0_OUT, d[3]);
        chk({tag, ".ce_acc"}, CE_ACC_OUT, d[2]);
        chk({tag, ".acc_clr"}, ACC_CLR, d[5]);
        chk({tag, ".op"}, OP_OUT, d[1:0]);
        chk({tag, ".latency"}, n, 3 + (is_imm ? 1 : 0) + waits_acc);
        lat = n;
        rd_q.delete();
        waits_acc = 0;
    endtask

    task automatic bench_reset_state();
        m_pc      = 4'd0;
        rd_q.delete();
        waits_acc = 0;
        in_read   = 0;
        wait_cnt  = 0;
    endtask

    initial begin
        int lat, extra, guard;
        RST_N = 1'b0; RUN = 1'b0; STEP = 1'b0; PROG_VALID = 1'b0; PROG_DATA = '0;
        {DEC_RESET, DEC_SEL, DEC_CE_R0, DEC_CE_ACC, DEC_OP} = '0;
        for (int i = 0; i < 16; i++) rom[i] = 4'h0;
        bench_reset_state();
        tick();
        tick();
        chk("rst.prog_rd", PROG_RD, 0);
        chk("rst.busy", BUSY, 0);
        chk("rst.retire", RETIRE, 0);
        chk("rst.instr", INSTRUCTION, 0);
        chk("rst.imm", IMM, 0);
        chk("rst.addr", PROG_ADDR, 0);
        chk("rst.strobes", {CE_R0_OUT, CE_ACC_OUT, ACC_CLR}, 0);
        RST_N = 1'b1;
        tick();

        // Directed program: plain, plain, LDI 9 with waits, plain, RST0.
        rom[0] = 4'h1; rom[1] = 4'h2; rom[2] = OPC_LDI; rom[3] = 4'h9;
        rom[4] = 4'h4; rom[5] = OPC_RST0;
        RUN = 1'b1;
        tick();
        chk("t1.c1_rd", PROG_RD, 1);
        chk("t1.c1_addr", PROG_ADDR, 0);
        run_instr("t1", 1, lat);
        chk("t1.cycle3", lat, 3);
        run_instr("t1b", 0, lat);
        wmin = 2; wmax = 2;
        run_instr("t2", 0, lat);
        chk("t2.total", lat, 8);
        chk("t2.imm9", IMM, 4'h9);
        wmin = 0; wmax = 0;
        run_instr("t3a", 0, lat);
        run_instr("t3", 0, lat);
        run_instr("t3next", 0, lat);
        RUN = 1'b0;
        tick();
        tick();
        chk("t3.idle_busy", BUSY, 0);

        // PC wrap: LDI at address F takes its operand from address 0.
        for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(12, 0));
        rom[15] = OPC_LDI;
        rom[0]  = 4'h3;
        RUN = 1'b1;
        guard = 0;
        while (m_pc != 4'hF && guard < 20) begin
            run_instr("wrapfill", 0, lat);
            guard++;
        end
        run_instr("wrap", 0, lat);
        chk("wrap.imm", IMM, 4'h3);
        chk("wrap.pc", m_pc, 4'h1);
        run_instr("wrapnext", 0, lat);
        RUN = 1'b0;
        tick();

        // STEP from IDLE; a second STEP while busy is ignored.
        wmin = 3; wmax = 3;
        STEP = 1'b1; tick(); STEP = 1'b0;
        tick();
        STEP = 1'b1; tick(); STEP = 1'b0;
        run_instr("step", 3, lat);
        chk("step.lat", lat, 6);
        wmin = 0; wmax = 0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (RETIRE) extra++;
        end
        chk("step.extra_retire", extra, 0);
        chk("step.busy", BUSY, 0);

        // Reset during FETCH; the late PROG_VALID must be ignored.
        RST_N = 1'b0; tick(); RST_N = 1'b1;
        bench_reset_state();
        rom[0] = 4'h5;
        mem_auto = 0; PROG_VALID = 1'b0;
        RUN = 1'b1;
        tick();
        chk("rst2.in_fetch", PROG_RD, 1);
        RST_N = 1'b0;
        #1;
        chk("rst2.prog_rd", PROG_RD, 0);
        chk("rst2.busy", BUSY, 0);
        chk("rst2.retire", RETIRE, 0);
        chk("rst2.addr", PROG_ADDR, 0);
        chk("rst2.instr", INSTRUCTION, 0);
        RUN = 1'b0; PROG_VALID = 1'b1; PROG_DATA = 4'h5;
        #1;
        RST_N = 1'b1;
        extra = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (RETIRE) extra++;
        end
        chk("rst2.late_valid_ir", INSTRUCTION, 0);
        chk("rst2.no_retire", extra, 0);
        chk("rst2.idle", BUSY, 0);
        PROG_VALID = 1'b0;
        mem_auto = 1;
        bench_reset_state();
        RUN = 1'b1;
        run_instr("postrst", 0, lat);

        // Random programs with random wait states.
        for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(15, 0));
        wmin = 0; wmax = 3;
        for (int k = 0; k < 60; k++) run_instr("rand", 0, lat);
        RUN = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("end.busy", BUSY, 0);
        chk("end.stray_strobes", stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
